// File: rtl/wb_port_sched.sv
// Writeback-port scheduler: arbitrates late load returns, a small in-order deferral
// queue and the WB stage onto the single RF write port and single CSR write port.
module wb_port_sched #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid_i,
    input  logic                     wb_rf_we_i,
    input  logic [4:0]               wb_rd_i,
    input  logic [XLEN-1:0]          wb_data_i,
    input  logic                     wb_csr_we_i,
    input  logic [11:0]              wb_csr_addr_i,
    input  logic [XLEN-1:0]          wb_csr_data_i,
    input  logic                     ld_valid_i,
    input  logic [4:0]               ld_rd_i,
    input  logic [XLEN-1:0]          ld_data_i,
    input  logic [4:0]               rs1_addr_i,
    input  logic [4:0]               rs2_addr_i,
    output logic                     wb_stall_o,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    output logic                     csr_we_o,
    output logic [11:0]              csr_waddr_o,
    output logic [XLEN-1:0]          csr_wdata_o,
    output logic                     rs1_pend_o,
    output logic                     rs2_pend_o,
    output logic [$clog2(DEPTH):0]   q_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef struct packed {
        logic            rfWe;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            csrWe;
        logic [11:0]     csrAddr;
        logic [XLEN-1:0] csrData;
    } entry_t;

    entry_t           entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wrPtr_q, rdPtr_q;
    logic [CW-1:0]    count_q;

    logic             qFull, qEmpty, accept, push, pop, bypass;
    entry_t           wbEntry, issueSrc;

    logic             rfWe_q, rfWe_d;
    logic [4:0]       rfWaddr_q, rfWaddr_d;
    logic [XLEN-1:0]  rfWdata_q, rfWdata_d;
    logic             csrWe_q, csrWe_d;
    logic [11:0]      csrWaddr_q, csrWaddr_d;
    logic [XLEN-1:0]  csrWdata_q, csrWdata_d;
    logic             rs1Pend, rs2Pend;

    assign qFull    = (count_q == FullCount);
    assign qEmpty   = (count_q == '0);
    assign accept   = wb_valid_i && !qFull;
    assign pop      = !ld_valid_i && !qEmpty;
    assign push     = accept && (ld_valid_i || !qEmpty);
    assign bypass   = accept && !ld_valid_i && qEmpty;
    assign wbEntry  = {wb_rf_we_i, wb_rd_i, wb_data_i, wb_csr_we_i, wb_csr_addr_i, wb_csr_data_i};
    assign issueSrc = qEmpty ? wbEntry : entry_q[rdPtr_q];

    // Port selection: load return first, then the queue head, then a bypassed WB input.
    always_comb begin
        rfWe_d     = 1'b0;
        rfWaddr_d  = '0;
        rfWdata_d  = '0;
        csrWe_d    = 1'b0;
        csrWaddr_d = '0;
        csrWdata_d = '0;
        if (ld_valid_i) begin
            rfWe_d    = (ld_rd_i != 5'd0);
            rfWaddr_d = ld_rd_i;
            rfWdata_d = ld_data_i;
        end else if (pop || bypass) begin
            rfWe_d     = issueSrc.rfWe && (issueSrc.rd != 5'd0);
            rfWaddr_d  = issueSrc.rd;
            rfWdata_d  = issueSrc.data;
            csrWe_d    = issueSrc.csrWe;
            csrWaddr_d = issueSrc.csrAddr;
            csrWdata_d = issueSrc.csrData;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (pop) begin
            valid_d[rdPtr_q] = 1'b0;
        end
        if (push) begin
            valid_d[wrPtr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                entry_q[wrPtr_q] <= wbEntry;
                wrPtr_q          <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rfWe_q     <= 1'b0;
            rfWaddr_q  <= '0;
            rfWdata_q  <= '0;
            csrWe_q    <= 1'b0;
            csrWaddr_q <= '0;
            csrWdata_q <= '0;
        end else begin
            rfWe_q     <= rfWe_d;
            rfWaddr_q  <= rfWaddr_d;
            rfWdata_q  <= rfWdata_d;
            csrWe_q    <= csrWe_d;
            csrWaddr_q <= csrWaddr_d;
            csrWdata_q <= csrWdata_d;
        end
    end

    // Only queued writes count as hazards; x0 is never pending.
    always_comb begin
        rs1Pend = 1'b0;
        rs2Pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && entry_q[i].rfWe) begin
                if (entry_q[i].rd == rs1_addr_i) begin
                    rs1Pend = 1'b1;
                end
                if (entry_q[i].rd == rs2_addr_i) begin
                    rs2Pend = 1'b1;
                end
            end
        end
        if (rs1_addr_i == 5'd0) begin
            rs1Pend = 1'b0;
        end
        if (rs2_addr_i == 5'd0) begin
            rs2Pend = 1'b0;
        end
    end

    assign wb_stall_o  = qFull;
    assign rf_we_o     = rfWe_q;
    assign rf_waddr_o  = rfWaddr_q;
    assign rf_wdata_o  = rfWdata_q;
    assign csr_we_o    = csrWe_q;
    assign csr_waddr_o = csrWaddr_q;
    assign csr_wdata_o = csrWdata_q;
    assign rs1_pend_o  = rs1Pend;
    assign rs2_pend_o  = rs2Pend;
    assign q_count_o   = count_q;

endmodule
